lane_scheduler: RTL and testbench

LANE_SCHEDULER -- requirements
Module: lane_scheduler

---
 rtl/lane_scheduler.sv | 137 +++++++++++++
 tb/tb_lane_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_scheduler.sv
// Lane scheduler: advances up to NUM_LANES independent object lanes (logs/cars) by one X
// step every period+1 frame_clk cycles, with wrap-around and IDLE/RUN/PAUSED control.
module lane_scheduler #(
    parameter int          NUM_LANES      = 4,
    parameter logic [21:0] DEFAULT_PERIOD = 22'd1500000,
    parameter logic [9:0]  WRAP_LO        = 10'd143,
    parameter logic [9:0]  WRAP_HI        = 10'd432
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_lane,
    input  logic [21:0]               cfg_period,
    input  logic                      cfg_dir,
    input  logic [9:0]                cfg_x,
    output logic                      cfg_ack,
    output logic [NUM_LANES*10-1:0]   lane_x,
    output logic [NUM_LANES-1:0]      moved,
    output logic                      running
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       cfg_open;
    logic       advance;
    logic       restore;

    // Stop beats start in IDLE, and stop beats pause in RUN/PAUSED.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!stop && start)
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (stop)
                    state_next = S_IDLE;
                else if (pause)
                    state_next = S_PAUSED;
            end
            S_PAUSED: begin
                if (stop)
                    state_next = S_IDLE;
                else if (!pause)
                    state_next = S_RUN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset)
            cfg_ack <= 1'b0;
        else
            cfg_ack <= cfg_we && cfg_open;
    end

    assign running  = (state == S_RUN);
    assign cfg_open = (state == S_IDLE);
    // A pause level freezes the lanes on the very edge it is first seen.
    assign advance  = (state == S_RUN) && !stop && !pause;
    assign restore  = (state != S_IDLE) && stop;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [21:0] period;
        logic        dir;
        logic [9:0]  home_x;
        logic [9:0]  pos;
        logic [21:0] cnt;
        logic        strobe;
        logic [9:0]  step;
        logic        hit;

        assign hit = cfg_we && cfg_open && (cfg_lane == 2'(i));

        always_comb begin
            step = pos;
            if (dir)
                step = (pos >= WRAP_HI) ? WRAP_LO : pos + 10'd1;
            else
                step = (pos <= WRAP_LO) ? WRAP_HI : pos - 10'd1;
        end

        // cnt >= period (not ==) keeps cnt bounded by period under any state.
        always_ff @(posedge frame_clk or negedge Reset) begin
            if (!Reset) begin
                period <= DEFAULT_PERIOD;
                dir    <= 1'b1;
                home_x <= WRAP_LO;
                pos    <= WRAP_LO;
                cnt    <= '0;
                strobe <= 1'b0;
            end else begin
                strobe <= 1'b0;
                if (hit) begin
                    period <= cfg_period;
                    dir    <= cfg_dir;
                    home_x <= cfg_x;
                    pos    <= cfg_x;
                    cnt    <= '0;
                end else if (restore) begin
                    pos <= home_x;
                    cnt <= '0;
                end else if (advance) begin
                    if (period == 22'd0) begin
                        cnt <= '0;
                    end else if (cnt >= period) begin
                        cnt    <= '0;
                        pos    <= step;
                        strobe <= 1'b1;
                    end else begin
                        cnt <= cnt + 22'd1;
                    end
                end
            end
        end

        assign lane_x[i*10 +: 10] = pos;
        assign moved[i]           = strobe;
    end

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed table-driven bench for lane_scheduler with hand-written pause and reset sequences.
module tb_lane_scheduler;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        stop;
    logic        pause;
    logic        cfg_we;
    logic [1:0]  cfg_lane;
    logic [21:0] cfg_period;
    logic        cfg_dir;
    logic [9:0]  cfg_x;
    logic        cfg_ack;
    logic [39:0] lane_x;
    logic [3:0]  moved;
    logic        running;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 frame_clk = ~frame_clk;

    lane_scheduler dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .cfg_we    (cfg_we),
        .cfg_lane  (cfg_lane),
        .cfg_period(cfg_period),
        .cfg_dir   (cfg_dir),
        .cfg_x     (cfg_x),
        .cfg_ack   (cfg_ack),
        .lane_x    (lane_x),
        .moved     (moved),
        .running   (running)
    );

    typedef struct {
        logic        start;
        logic        stop;
        logic        pause;
        logic        cfg_we;
        logic [1:0]  cfg_lane;
        logic [21:0] cfg_period;
        logic        cfg_dir;
        logic [9:0]  cfg_x;
        logic        exp_ack;
        logic        exp_running;
        logic [3:0]  exp_moved;
        logic [39:0] exp_x;
    } vec_t;

    vec_t vecs [30];

    function automatic vec_t mk(input bit st, input bit sp, input bit pa, input bit we,
                                input int lane, input int per, input bit d, input int x,
                                input bit ack, input bit run, input logic [3:0] mv,
                                input int x3, input int x2, input int x1, input int x0);
        vec_t v;
        v.start       = st;
        v.stop        = sp;
        v.pause       = pa;
        v.cfg_we      = we;
        v.cfg_lane    = 2'(lane);
        v.cfg_period  = 22'(per);
        v.cfg_dir     = d;
        v.cfg_x       = 10'(x);
        v.exp_ack     = ack;
        v.exp_running = run;
        v.exp_moved   = mv;
        v.exp_x       = {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
        return v;
    endfunction

    task automatic check_output(input string name, input logic [39:0] actual,
                                input logic [39:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic drive_idle();
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        cfg_we     = 1'b0;
        cfg_lane   = 2'd0;
        cfg_period = 22'd0;
        cfg_dir    = 1'b0;
        cfg_x      = 10'd0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        start      = v.start;
        stop       = v.stop;
        pause      = v.pause;
        cfg_we     = v.cfg_we;
        cfg_lane   = v.cfg_lane;
        cfg_period = v.cfg_period;
        cfg_dir    = v.cfg_dir;
        cfg_x      = v.cfg_x;
        tick();
    endtask

    task automatic cfg_write(input int lane, input int per, input bit d, input int x);
        drive_idle();
        cfg_we     = 1'b1;
        cfg_lane   = 2'(lane);
        cfg_period = 22'(per);
        cfg_dir    = d;
        cfg_x      = 10'(x);
        tick();
        drive_idle();
        check_output($sformatf("cfg lane%0d ack", lane), {39'd0, cfg_ack}, 40'd1);
    endtask

    initial begin
        logic [39:0] held_x;

        // Columns: start stop pause we | lane period dir x | ack run moved | x3 x2 x1 x0
        vecs[0]  = mk(0,0,0,1, 0,3,1,200,   1,0,4'b0000, 143,143,143,200);
        vecs[1]  = mk(1,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,200);
        vecs[2]  = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,200);
        vecs[3]  = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,200);
        vecs[4]  = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,200);
        vecs[5]  = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0001, 143,143,143,201);
        vecs[6]  = mk(0,0,0,1, 0,7,0,300,   0,1,4'b0000, 143,143,143,201);
        vecs[7]  = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,201);
        vecs[8]  = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,201);
        vecs[9]  = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0001, 143,143,143,202);
        vecs[10] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,202);
        vecs[11] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,202);
        vecs[12] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,143,202);
        vecs[13] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0001, 143,143,143,203);
        vecs[14] = mk(0,1,0,0, 0,0,0,0,     0,0,4'b0000, 143,143,143,200);
        vecs[15] = mk(1,1,0,0, 0,0,0,0,     0,0,4'b0000, 143,143,143,200);
        vecs[16] = mk(0,0,1,0, 0,0,0,0,     0,0,4'b0000, 143,143,143,200);
        vecs[17] = mk(0,0,0,1, 1,0,1,432,   1,0,4'b0000, 143,143,432,200);
        vecs[18] = mk(0,0,0,1, 2,1,0,143,   1,0,4'b0000, 143,143,432,200);
        vecs[19] = mk(0,0,0,1, 0,0,1,200,   1,0,4'b0000, 143,143,432,200);
        vecs[20] = mk(1,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,432,200);
        vecs[21] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,432,200);
        vecs[22] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0100, 143,432,432,200);
        vecs[23] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,432,432,200);
        vecs[24] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0100, 143,431,432,200);
        vecs[25] = mk(0,1,0,0, 0,0,0,0,     0,0,4'b0000, 143,143,432,200);
        vecs[26] = mk(1,0,0,1, 1,1,1,432,   1,1,4'b0000, 143,143,432,200);
        vecs[27] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0000, 143,143,432,200);
        vecs[28] = mk(0,0,0,0, 0,0,0,0,     0,1,4'b0110, 143,432,143,200);
        vecs[29] = mk(0,1,0,0, 0,0,0,0,     0,0,4'b0000, 143,143,432,200);

        Reset = 1'b0;
        drive_idle();
        #12;
        check_output("reset running", {39'd0, running}, 40'd0);
        check_output("reset ack",     {39'd0, cfg_ack}, 40'd0);
        check_output("reset moved",   {36'd0, moved},   40'd0);
        check_output("reset lane_x",  lane_x,           {4{10'd143}});
        Reset = 1'b1;
        tick();

        for (int i = 0; i < 30; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("row%0d ack", i),     {39'd0, cfg_ack}, {39'd0, vecs[i].exp_ack});
            check_output($sformatf("row%0d running", i), {39'd0, running}, {39'd0, vecs[i].exp_running});
            check_output($sformatf("row%0d moved", i),   {36'd0, moved},   {36'd0, vecs[i].exp_moved});
            check_output($sformatf("row%0d lane_x", i),  lane_x,           vecs[i].exp_x);
        end
        drive_idle();

        // Pause mid-count on lane3 (period 5), then stop from PAUSED.
        cfg_write(1, 0, 1'b1, 432);
        cfg_write(2, 0, 1'b0, 143);
        cfg_write(3, 5, 1'b1, 300);
        held_x = {10'd300, 10'd143, 10'd432, 10'd200};
        check_output("pause cfg lane_x", lane_x, held_x);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("pause start running", {39'd0, running}, 40'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output($sformatf("pre-pause moved%0d", k), {36'd0, moved}, 40'd0);
        end
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_output($sformatf("paused running%0d", k), {39'd0, running}, 40'd0);
            check_output($sformatf("paused moved%0d", k),   {36'd0, moved},   40'd0);
            check_output($sformatf("paused lane_x%0d", k),  lane_x,           held_x);
        end
        pause = 1'b0;
        tick();
        check_output("resume running", {39'd0, running}, 40'd1);
        check_output("resume moved",   {36'd0, moved},   40'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_output($sformatf("remaining moved%0d", k), {36'd0, moved}, 40'd0);
        end
        tick();
        check_output("resume strobe moved",  {36'd0, moved}, 40'b1000);
        check_output("resume strobe lane_x", lane_x, {10'd301, 10'd143, 10'd432, 10'd200});
        pause = 1'b1;
        tick();
        check_output("repause running", {39'd0, running}, 40'd0);
        stop = 1'b1;
        tick();
        drive_idle();
        check_output("paused stop running", {39'd0, running}, 40'd0);
        check_output("paused stop moved",   {36'd0, moved},   40'd0);
        check_output("paused stop lane_x",  lane_x,           held_x);

        // Asynchronous reset mid-RUN discards all lane configuration.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("prereset running", {39'd0, running}, 40'd1);
        tick();
        tick();
        #2;
        Reset = 1'b0;
        #1;
        check_output("async reset running", {39'd0, running}, 40'd0);
        check_output("async reset ack",     {39'd0, cfg_ack}, 40'd0);
        check_output("async reset moved",   {36'd0, moved},   40'd0);
        check_output("async reset lane_x",  lane_x,           {4{10'd143}});
        repeat (2) @(posedge frame_clk);
        #3;
        Reset = 1'b1;
        tick();
        check_output("post reset idle running", {39'd0, running}, 40'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("post reset start running", {39'd0, running}, 40'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_output($sformatf("defaults moved%0d", k),  {36'd0, moved}, 40'd0);
            check_output($sformatf("defaults lane_x%0d", k), lane_x, {4{10'd143}});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
